// File: rtl/some_vip_tx_if.sv
// Valid/ready byte link between the some_vip transmitter and its receiver.
// Carries the offered byte one way and the returned response byte the other.
interface some_vip_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;
    logic [DATA_W-1:0] data_i;

    modport master (output valid_o, output data_o, input ready_i, input data_i);
    modport slave  (input valid_o, input data_o, output ready_i, output data_i);
endinterface

// File: rtl/some_vip_tx.sv
// some_vip transmit initiator: FIFO-buffered byte source driving a valid/ready link,
// with an output register, an empty-FIFO bypass path and response capture.
module some_vip_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o,
    output logic                     resp_valid_o,
    output logic [DATA_W-1:0]        resp_data_o,
    output logic [CNT_W-1:0]         sent_cnt_o,
    some_vip_tx_if.master            link
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic {IDLE, SEND} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              ovf_q, ovf_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [CNT_W-1:0]  sent_cnt_q, sent_cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic xfer, out_free, fifo_nempty, pop, bypass, wr;

    // Datapath decisions: flush wins over pop, bypass and write.
    always_comb begin
        xfer        = (state_q == SEND) && link.ready_i;
        out_free    = (state_q == IDLE) || xfer;
        fifo_nempty = (count_q != '0);
        pop         = out_free && fifo_nempty && !flush_i;
        bypass      = out_free && !fifo_nempty && push_i && !full_q && !flush_i;
        wr          = push_i && !full_q && !bypass && !flush_i;
    end

    // Next state and register updates.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        resp_valid_d = xfer;
        resp_data_d  = resp_data_q;
        sent_cnt_d   = sent_cnt_q;

        if (pop) begin
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            state_d  = SEND;
        end else if (bypass) begin
            data_d  = push_data_i;
            state_d = SEND;
        end else if (xfer) begin
            state_d = IDLE;
        end

        if (wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            count_d = count_q + OCC_W'(wr) - OCC_W'(pop);
            if (push_i && full_q) begin
                ovf_d = 1'b1;
            end
        end

        if (xfer) begin
            resp_data_d = link.data_i;
            sent_cnt_d  = sent_cnt_q + CNT_W'(1);
        end

        full_d = (count_d == OCC_W'(DEPTH));
    end

    // Reset input is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= IDLE;
            data_q       <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            ovf_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            sent_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            full_q       <= full_d;
            ovf_q        <= ovf_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            sent_cnt_q   <= sent_cnt_d;
        end
    end

    // Storage array needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign link.valid_o = (state_q == SEND);
    assign link.data_o  = data_q;
    assign full_o       = full_q;
    assign count_o      = count_q;
    assign ovf_o        = ovf_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign sent_cnt_o   = sent_cnt_q;
endmodule

// File: tb/tb_some_vip_tx.sv
// Directed bench for some_vip_tx: inputs driven and outputs sampled on the falling edge.
module tb_some_vip_tx;
    logic        clk;
    logic        rst_n;
    logic        push_i;
    logic [7:0]  push_data_i;
    logic        flush_i;
    logic        full_o;
    logic [3:0]  count_o;
    logic        ovf_o;
    logic        resp_valid_o;
    logic [7:0]  resp_data_o;
    logic [15:0] sent_cnt_o;

    int checks   = 0;
    int failures = 0;

    some_vip_tx_if #(.DATA_W(8)) link ();

    some_vip_tx #(.DATA_W(8), .DEPTH(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push_i),
        .push_data_i  (push_data_i),
        .flush_i      (flush_i),
        .full_o       (full_o),
        .count_o      (count_o),
        .ovf_o        (ovf_o),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .sent_cnt_o   (sent_cnt_o),
        .link         (link)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_b;
        logic       pv, phs, hs;
        logic [7:0] pd;
        int         pushed, delivered, cyc;

        rst_n = 1'b0; push_i = 1'b0; push_data_i = '0; flush_i = 1'b0;
        link.ready_i = 1'b0; link.data_i = '0;
        #2 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_valid", 32'(link.valid_o), 32'(0));
        chk("rst_data", 32'(link.data_o), 32'(0));
        chk("rst_count", 32'(count_o), 32'(0));
        chk("rst_full", 32'(full_o), 32'(0));
        chk("rst_sent", 32'(sent_cnt_o), 32'(0));
        rst_n = 1'b0;

        // Single bypass transfer with response capture
        @(negedge clk);
        push_i = 1'b1; push_data_i = 8'hA5; link.ready_i = 1'b1; link.data_i = 8'h3C;
        @(negedge clk);
        push_i = 1'b0;
        chk("t1_valid", 32'(link.valid_o), 32'(1));
        chk("t1_data", 32'(link.data_o), 32'hA5);
        chk("t1_resp_valid_early", 32'(resp_valid_o), 32'(0));
        @(negedge clk);
        link.ready_i = 1'b0;
        chk("t1_resp_valid", 32'(resp_valid_o), 32'(1));
        chk("t1_resp_data", 32'(resp_data_o), 32'h3C);
        chk("t1_sent", 32'(sent_cnt_o), 32'(1));
        chk("t1_valid_low", 32'(link.valid_o), 32'(0));
        @(negedge clk);
        chk("t1_resp_pulse_end", 32'(resp_valid_o), 32'(0));

        // Fill to full with ready low, then drain
        for (int i = 1; i <= 10; i++) begin
            push_i = 1'b1; push_data_i = 8'(i);
            @(negedge clk);
        end
        push_i = 1'b0;
        chk("t2_valid", 32'(link.valid_o), 32'(1));
        chk("t2_data_held", 32'(link.data_o), 32'h01);
        chk("t2_count", 32'(count_o), 32'(8));
        chk("t2_full", 32'(full_o), 32'(1));
        chk("t2_ovf", 32'(ovf_o), 32'(1));
        link.ready_i = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            @(negedge clk);
            chk("t2_drain_data", 32'(link.data_o), 32'(k));
            chk("t2_drain_count", 32'(count_o), 32'(9 - k));
        end
        @(negedge clk);
        link.ready_i = 1'b0;
        chk("t2_valid_end", 32'(link.valid_o), 32'(0));
        chk("t2_sent", 32'(sent_cnt_o), 32'(10));
        chk("t2_full_end", 32'(full_o), 32'(0));

        // Random ready, 100 streamed bytes, order and stability
        pushed = 0; delivered = 0; cyc = 0; pv = 1'b0; phs = 1'b0; pd = '0;
        while (delivered < 100 && cyc < 3000) begin
            if (pv && !phs) begin
                chk("t3_hold_valid", 32'(link.valid_o), 32'(1));
                chk("t3_hold_data", 32'(link.data_o), 32'(pd));
            end
            if (pushed < 100 && !full_o && ($urandom_range(0, 3) != 0)) begin
                push_i = 1'b1; push_data_i = 8'(pushed * 7 + 3);
                q.push_back(8'(pushed * 7 + 3));
                pushed++;
            end else begin
                push_i = 1'b0;
            end
            link.ready_i = 1'($urandom_range(0, 1));
            hs = link.valid_o && link.ready_i;
            if (hs) begin
                exp_b = q.pop_front();
                chk("t3_order", 32'(link.data_o), 32'(exp_b));
                delivered++;
            end
            pv = link.valid_o; pd = link.data_o; phs = hs;
            @(negedge clk);
            cyc++;
        end
        push_i = 1'b0; link.ready_i = 1'b0;
        chk("t3_timeout", 32'(delivered), 32'(100));
        chk("t3_sent", 32'(sent_cnt_o), 32'(110));
        chk("t3_ovf_clean", 32'(ovf_o), 32'(1));
        @(negedge clk);
        chk("t3_valid_end", 32'(link.valid_o), 32'(0));

        // Pointer wrap at steady occupancy of three
        for (int i = 0; i < 4; i++) begin
            push_i = 1'b1; push_data_i = 8'(8'hB0 + i);
            @(negedge clk);
        end
        chk("t4_pre_count", 32'(count_o), 32'(3));
        chk("t4_pre_data", 32'(link.data_o), 32'hB0);
        link.ready_i = 1'b1; push_data_i = 8'hB4;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk("t4_wrap_data", 32'(link.data_o), 32'(8'hB0 + k));
            chk("t4_wrap_count", 32'(count_o), 32'(3));
            if (k < 20) push_data_i = 8'(8'hB0 + k + 4);
            else push_i = 1'b0;
        end
        for (int k = 21; k <= 23; k++) begin
            @(negedge clk);
            chk("t4_tail_data", 32'(link.data_o), 32'(8'hB0 + k));
            chk("t4_tail_count", 32'(count_o), 32'(23 - k));
        end
        @(negedge clk);
        link.ready_i = 1'b0;
        chk("t4_valid_end", 32'(link.valid_o), 32'(0));

        // Flush with a held output byte
        for (int i = 0; i < 6; i++) begin
            push_i = 1'b1;
            push_data_i = (i == 0) ? 8'h55 : 8'(8'h60 + i - 1);
            @(negedge clk);
        end
        push_i = 1'b0;
        chk("t5_pre_count", 32'(count_o), 32'(5));
        chk("t5_pre_data", 32'(link.data_o), 32'h55);
        chk("t5_pre_ovf", 32'(ovf_o), 32'(1));
        flush_i = 1'b1; push_i = 1'b1; push_data_i = 8'h99;
        @(negedge clk);
        flush_i = 1'b0; push_i = 1'b0;
        chk("t5_count", 32'(count_o), 32'(0));
        chk("t5_ovf", 32'(ovf_o), 32'(0));
        chk("t5_valid", 32'(link.valid_o), 32'(1));
        chk("t5_data", 32'(link.data_o), 32'h55);
        link.ready_i = 1'b1; link.data_i = 8'hE1;
        @(negedge clk);
        link.ready_i = 1'b0;
        chk("t5_valid_end", 32'(link.valid_o), 32'(0));
        chk("t5_resp", 32'(resp_data_o), 32'hE1);
        @(negedge clk);
        chk("t5_count_end", 32'(count_o), 32'(0));
        chk("t5_idle", 32'(link.valid_o), 32'(0));

        // Asynchronous reset mid-transfer
        for (int i = 0; i < 4; i++) begin
            push_i = 1'b1; push_data_i = 8'(8'h10 + i);
            @(negedge clk);
        end
        push_i = 1'b0;
        chk("t6_pre_valid", 32'(link.valid_o), 32'(1));
        chk("t6_pre_count", 32'(count_o), 32'(3));
        #2 rst_n = 1'b1;
        #1;
        chk("t6_valid", 32'(link.valid_o), 32'(0));
        chk("t6_data", 32'(link.data_o), 32'(0));
        chk("t6_count", 32'(count_o), 32'(0));
        chk("t6_sent", 32'(sent_cnt_o), 32'(0));
        chk("t6_resp_data", 32'(resp_data_o), 32'(0));
        @(negedge clk);
        rst_n = 1'b0;
        push_i = 1'b1; push_data_i = 8'h77; link.ready_i = 1'b1; link.data_i = 8'h42;
        @(negedge clk);
        push_i = 1'b0;
        chk("t6_post_valid", 32'(link.valid_o), 32'(1));
        chk("t6_post_data", 32'(link.data_o), 32'h77);
        @(negedge clk);
        link.ready_i = 1'b0;
        chk("t6_post_sent", 32'(sent_cnt_o), 32'(1));
        chk("t6_post_resp", 32'(resp_data_o), 32'h42);
        chk("t6_post_idle", 32'(link.valid_o), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/some_vip_tx.md
# some_vip_tx

Transmit-side initiator for the some_vip valid/ready byte interface. It buffers bytes pushed by local logic in a small FIFO and presents them one at a time on valid_o/data_o, holding each until the receiver asserts ready_i. It captures the receiver's returned byte (data_i) on every completed handshake. It sits on the master side of the link and connects port-for-port to the receiving block.

## Interface
- DATA_W, 8, width of the pushed, transmitted and response data
- DEPTH, 8, FIFO entries; power of two, ≥ 2
- CNT_W, 16, width of the transfer counter
- clk  input  1  clock; all logic on the rising edge
- rst_n  input  1  reset; asynchronous, active-high (asserted = 1)
- push_i  input  1  write one byte into the FIFO this cycle
- push_data_i  input  DATA_W  byte written when push_i = 1
- flush_i  input  1  synchronous clear of the queued (not yet presented) FIFO entries
- full_o  output  1  FIFO holds DEPTH entries
- count_o  output  $clog2(DEPTH)+1  FIFO occupancy; excludes the output register
- ovf_o  output  1  sticky flag: a push was dropped because the FIFO was full
- valid_o  output  1  data_o holds a byte being offered
- ready_i  input  1  receiver accepts the offered byte this cycle
- data_o  output  DATA_W  offered byte (registered)
- data_i  input  DATA_W  response byte from the receiver
- resp_valid_o  output  1  one-cycle pulse: resp_data_o was updated
- resp_data_o  output  DATA_W  last captured response byte
- sent_cnt_o  output  CNT_W  number of completed handshakes; wraps modulo 2^CNT_W

## Operation
- Handshake: a transfer completes on a rising edge where valid_o = 1 and ready_i = 1.
- Valid rule: once valid_o rises, valid_o and data_o stay constant until the transfer completes. No retraction, including during flush.
- Two-state FSM:
  - IDLE (valid_o = 0): if the FIFO is non-empty, load its head into data_o and go to SEND. Otherwise, if push_i is high and full_o is low, load push_data_i directly into data_o (bypass) and go to SEND.
  - SEND (valid_o = 1): on a completed transfer, load the FIFO head if present and stay in SEND. Else take the bypass push if present and stay in SEND. Else go to IDLE.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits that wrap DEPTH-1 → 0.
  - Occupancy counter: +1 on an accepted write, −1 on a read into the output register, unchanged when both happen.
- Push into a full FIFO (full_o = 1 at the edge) is dropped and sets ovf_o, even if a pop occurs in the same cycle.
- Push is written to the FIFO unless the bypass path consumed it.
- Bypass consumes a push only when the FIFO is empty and the output register is free (IDLE, or SEND with a completed transfer).
- flush_i:
  - Zeroes the pointers and count, and clears ovf_o.
  - Does not affect the output register, sent_cnt_o, or the response path.
  - A push in the same cycle as flush_i is dropped.
- Response capture: on each completed transfer, resp_data_o ← data_i, resp_valid_o = 1 for one cycle, and sent_cnt_o += 1.

## Timing
- Reset values: valid_o = 0, data_o = 0, full_o = 0, count_o = 0, ovf_o = 0, resp_valid_o = 0, resp_data_o = 0, sent_cnt_o = 0. FSM = IDLE, pointers = 0.
- Reset mid-transfer aborts it; the held byte is lost.
- Latency, push to valid_o:
  - Empty FIFO, IDLE: 1 cycle.
  - Behind a pending output: valid_o is already high; the byte follows the transfers ahead of it.
- Throughput: one byte per cycle while ready_i = 1 and data is available, with no bubble between back-to-back transfers.
- ready_i is ignored while valid_o = 0; it may be asserted before valid_o.
- resp_valid_o and the sent_cnt_o increment appear in the cycle after the completing edge.
- full_o and count_o are registered and reflect the state after the last edge.
- Maximum data in flight is DEPTH + 1 bytes: DEPTH in the FIFO plus one in the output register.

## Test plan
- Reset then push 0xA5 with ready_i = 1: valid_o = 1 and data_o = 0xA5 one cycle later. Transfer completes; resp_data_o = data_i (drive 0x3C); resp_valid_o pulses; sent_cnt_o = 1.
- Hold ready_i = 0 and push 0x01..0x0A (10 bytes, DEPTH = 8):
  - data_o = 0x01 held stable with valid_o = 1.
  - FIFO holds 0x02..0x09; full_o = 1; count_o = 8.
  - 0x0A is dropped; ovf_o = 1.
  - Release ready_i: 0x01..0x09 appear in order on consecutive cycles, then valid_o = 0.
- ready_i toggles randomly while 100 pushes stream in without overflow: every byte is delivered exactly once and in order; sent_cnt_o = 100; valid_o/data_o never change without a handshake.
- Pointer wrap: 20 push/pop cycles with ready_i = 1 and the FIFO partly full. Order is preserved across the DEPTH-1 → 0 wrap; count_o is correct at each step.
- flush_i with valid_o = 1 (data_o = 0x55) and 5 queued entries: count_o = 0 and ovf_o = 0 next cycle. 0x55 is still delivered when ready_i rises, then valid_o = 0.
- rst_n pulsed while valid_o = 1 and the FIFO is non-empty: all outputs return to their reset values asynchronously. A subsequent push of 0x77 is delivered normally.
